pc_run_ctrl: RTL

- Program-counter stage that sits directly upstream of the single-cycle I-format CPU datapath.
- Holds the PC register that drives the CPU's instruction address input and captures the CPU's computed next address each committing cycle.
- Adds run control: idle, free-run, single-step, halt on jump-to-self, fault on misaligned target or watchdog expiry.
- Exports a commit enable; the top level ANDs it into RegWrite and MemWrite so that non-committing cycles leave architectural state untouched.

---
 rtl/pc_run_ctrl.sv | 119 +++++++++++
 1 files changed

// File: rtl/pc_run_ctrl.sv
// Program-counter stage with run control for the single-cycle CPU.
// Drives the instruction address and gates architectural writes.
module pc_run_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned WATCHDOG = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        step_mode,
  input  logic        step,
  input  logic [31:0] next_pc,
  output logic [31:0] pc,
  output logic        exec_en,
  output logic [2:0]  state,
  output logic [1:0]  fault_code,
  output logic [31:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_STEP   = 3'd2,
    S_HALTED = 3'd3,
    S_FAULT  = 3'd4
  } state_t;

  localparam logic [31:0] WD = 32'(WATCHDOG);

  state_t      cur;
  state_t      nxt;
  state_t      mode_tgt;
  state_t      commit_tgt;
  logic [31:0] ret_inc;
  logic        misal;
  logic        self_jmp;
  logic        wd_hit;
  logic        advance;

  assign state    = cur;
  assign ret_inc  = (retired == 32'hFFFF_FFFF) ? retired : retired + 32'd1;
  assign misal    = next_pc[1:0] != 2'b00;
  assign self_jmp = next_pc == pc;
  assign wd_hit   = (WD != 32'd0) && (ret_inc == WD);
  assign advance  = !misal && !self_jmp && !wd_hit;
  assign mode_tgt = step_mode ? S_STEP : S_RUN;

  // Priority: misalignment, then jump-to-self, then watchdog.
  always_comb begin
    commit_tgt = mode_tgt;
    if (misal)
      commit_tgt = S_FAULT;
    else if (self_jmp)
      commit_tgt = S_HALTED;
    else if (wd_hit)
      commit_tgt = S_FAULT;
  end

  always_ff @(posedge clk) begin
    if (rst)
      cur <= S_IDLE;
    else
      cur <= nxt;
  end

  always_comb begin
    nxt = cur;
    unique case (cur)
      S_IDLE:
        if (start) nxt = mode_tgt;
      S_RUN:
        nxt = commit_tgt;
      S_STEP:
        if (step)
          nxt = commit_tgt;
        else if (!step_mode)
          nxt = S_RUN;
      S_HALTED,
      S_FAULT:
        if (start) nxt = S_IDLE;
      default:
        nxt = S_IDLE;
    endcase
  end

  always_comb begin
    exec_en = 1'b0;
    unique case (cur)
      S_RUN:   exec_en = 1'b1;
      S_STEP:  exec_en = step;
      default: exec_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC;
      retired    <= 32'd0;
      fault_code <= 2'b00;
    end else if (exec_en) begin
      retired <= ret_inc;
      if (misal)
        fault_code <= 2'b01;
      else if (!self_jmp && wd_hit)
        fault_code <= 2'b10;
      if (advance)
        pc <= next_pc;
    end else if (cur == S_IDLE) begin
      if (start)
        retired <= 32'd0;
    end else if (cur == S_HALTED || cur == S_FAULT) begin
      if (start) begin
        pc         <= RESET_PC;
        fault_code <= 2'b00;
      end
    end
  end

endmodule
